// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared state encoding and default sizes for the MMU tile sequencer
// Ports: none (package)
package mmu_pkg;

    localparam int ARRAY_SIZE_DEF = 16;
    localparam int ACT_LEN_DEF    = 16;
    localparam int ADDR_W_DEF     = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD_W = 3'd1;
    localparam state_t ST_STREAM = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/mmu_phase_cnt.sv
// rtl/mmu_phase_cnt.sv - beat counter shared by the weight-load and activation-stream phases
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_clr        synchronous clear (wins over i_en)
//   i_en         count one beat
//   i_last       terminal value for the current phase
//   o_cnt        current count
//   o_tc         o_cnt equals i_last
module mmu_phase_cnt #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_last,
    output logic [ADDR_W-1:0] o_cnt,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + ADDR_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/mmu_tile_ctrl.sv
// rtl/mmu_tile_ctrl.sv - tile sequencer: weight load, activation stream, drain handshake
// Ports:
//   clk, rst_n                clock, async active-low reset
//   start_i                   tile request, taken only while ready_o=1
//   stall_i                   buffer not ready; freezes weight/activation beats
//   cnt_done_i                drain complete from the drain Counter
//   ready_o, busy_o           idle / tile in flight
//   w_load_o, w_addr_o        weight shift enable and buffer address
//   act_valid_o, act_addr_o   activation valid and buffer address
//   cnt_start_o               one-cycle start pulse to the drain Counter
//   done_o                    one-cycle tile-complete pulse
module mmu_tile_ctrl
    import mmu_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int ACT_LEN    = ACT_LEN_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              cnt_done_i,
    output logic              ready_o,
    output logic              w_load_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic              act_valid_o,
    output logic [ADDR_W-1:0] act_addr_o,
    output logic              cnt_start_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(ARRAY_SIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(ACT_LEN - 1);

    // r_state names the phase whose next beat is issued at the coming edge;
    // the registered outputs therefore trail it by one cycle.
    state_t            r_state;
    state_t            w_phase;
    logic              r_cnt_fired;
    logic              r_ready;
    logic              r_busy;
    logic              r_w_load;
    logic              r_act_valid;
    logic              r_cnt_start;
    logic              r_done;
    logic [ADDR_W-1:0] r_w_addr;
    logic [ADDR_W-1:0] r_act_addr;
    logic [ADDR_W-1:0] w_cnt;
    logic [ADDR_W-1:0] w_last;
    logic              w_tc;
    logic              w_beat_phase;
    logic              w_issue;
    logic              w_clr;

    // An accepted start issues weight beat 0 on the same edge.
    always_comb begin
        w_phase = r_state;
        if (r_state == ST_IDLE && start_i) begin
            w_phase = ST_LOAD_W;
        end
    end

    assign w_beat_phase = (w_phase == ST_LOAD_W) || (w_phase == ST_STREAM);
    assign w_issue      = w_beat_phase && !stall_i;
    assign w_last       = (w_phase == ST_STREAM) ? LAST_A : LAST_W;
    assign w_clr        = !w_beat_phase || (w_issue && w_tc);

    mmu_phase_cnt #(
        .ADDR_W (ADDR_W)
    ) u_phase_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_en   (w_issue),
        .i_last (w_last),
        .o_cnt  (w_cnt),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt_fired <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_w_load    <= 1'b0;
            r_w_addr    <= '0;
            r_act_valid <= 1'b0;
            r_act_addr  <= '0;
            r_cnt_start <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_w_load    <= 1'b0;
            r_act_valid <= 1'b0;
            r_cnt_start <= 1'b0;
            r_done      <= 1'b0;
            case (w_phase)
                ST_LOAD_W: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                    if (w_issue) begin
                        r_w_load <= 1'b1;
                        r_w_addr <= w_cnt;
                    end
                    r_state <= (w_issue && w_tc) ? ST_STREAM : ST_LOAD_W;
                end
                ST_STREAM: begin
                    r_w_addr <= '0;
                    if (w_issue) begin
                        r_act_valid <= 1'b1;
                        r_act_addr  <= w_cnt;
                    end
                    r_state <= (w_issue && w_tc) ? ST_DRAIN : ST_STREAM;
                end
                ST_DRAIN: begin
                    // First DRAIN edge only fires the Counter; cnt_done_i counts
                    // from the cycle cnt_start_o is visible onward.
                    r_act_addr <= '0;
                    if (!r_cnt_fired) begin
                        r_cnt_start <= 1'b1;
                        r_cnt_fired <= 1'b1;
                    end else if (cnt_done_i) begin
                        r_done      <= 1'b1;
                        r_cnt_fired <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = r_ready;
    assign busy_o      = r_busy;
    assign w_load_o    = r_w_load;
    assign w_addr_o    = r_w_addr;
    assign act_valid_o = r_act_valid;
    assign act_addr_o  = r_act_addr;
    assign cnt_start_o = r_cnt_start;
    assign done_o      = r_done;

endmodule

// File: tb/tb_mmu_tile_ctrl.sv
// tb/tb_mmu_tile_ctrl.sv - self-checking bench for mmu_tile_ctrl
module tb_mmu_tile_ctrl;

    localparam int AS    = 4;
    localparam int AL    = 6;
    localparam int AW    = 8;
    localparam int CNT_D = 7;
    localparam int NV    = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic          stall_i;
    logic          cnt_done_i;
    logic          ready_o;
    logic          w_load_o;
    logic [AW-1:0] w_addr_o;
    logic          act_valid_o;
    logic [AW-1:0] act_addr_o;
    logic          cnt_start_o;
    logic          busy_o;
    logic          done_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmu_tile_ctrl #(
        .ARRAY_SIZE (AS),
        .ACT_LEN    (AL),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .stall_i     (stall_i),
        .cnt_done_i  (cnt_done_i),
        .ready_o     (ready_o),
        .w_load_o    (w_load_o),
        .w_addr_o    (w_addr_o),
        .act_valid_o (act_valid_o),
        .act_addr_o  (act_addr_o),
        .cnt_start_o (cnt_start_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Reference model: a tile is a queue of beats (weights then activations),
    // popped one per unstalled edge, followed by the Counter handshake.
    typedef struct packed {
        bit         is_act;
        logic [7:0] addr;
    } beat_t;

    beat_t      mq[$];
    int         m_mode;   // 0 idle, 1 beats, 2 fire counter, 3 wait counter, 4 done
    bit         e_rdy, e_wl, e_av, e_cs, e_bsy, e_dn;
    logic [7:0] e_wa, e_aa;

    int wq[$];
    int aq[$];
    bit emu_on = 1'b0;
    int emu_timer = -1;

    typedef struct {
        bit         s, st, cd;
        bit         rdy, wl;
        logic [7:0] wa;
        bit         av;
        logic [7:0] aa;
        bit         cs, bsy, dn;
    } vec_t;

    vec_t tv[NV];

    function automatic logic [21:0] pack(bit r, bit wl, logic [7:0] wa, bit av,
                                         logic [7:0] aa, bit cs, bit b, bit d);
        return {r, wl, wa, av, aa, cs, b, d};
    endfunction

    function automatic logic [21:0] dut_vec();
        return pack(ready_o, w_load_o, w_addr_o, act_valid_o, act_addr_o,
                    cnt_start_o, busy_o, done_o);
    endfunction

    function automatic vec_t mk(bit s, bit st, bit cd, bit rdy, bit wl, int wa,
                                bit av, int aa, bit cs, bit bsy, bit dn);
        vec_t v;
        v.s = s; v.st = st; v.cd = cd; v.rdy = rdy; v.wl = wl; v.wa = 8'(wa);
        v.av = av; v.aa = 8'(aa); v.cs = cs; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, req);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_mode = 0;
        e_rdy = 1; e_wl = 0; e_av = 0; e_cs = 0; e_bsy = 0; e_dn = 0;
        e_wa = 0; e_aa = 0;
    endfunction

    function automatic void model_issue(bit st);
        beat_t b;
        if (mq[0].is_act) e_wa = 0;
        if (!st) begin
            b = mq.pop_front();
            if (b.is_act) begin e_av = 1; e_aa = b.addr; end
            else          begin e_wl = 1; e_wa = b.addr; end
            if (mq.size() == 0) m_mode = 2;
        end
    endfunction

    function automatic void model_step(bit s, bit st, bit cd);
        beat_t b;
        e_wl = 0; e_av = 0; e_cs = 0; e_dn = 0;
        case (m_mode)
            0: if (s) begin
                mq.delete();
                for (int i = 0; i < AS; i++) begin b.is_act = 0; b.addr = 8'(i); mq.push_back(b); end
                for (int i = 0; i < AL; i++) begin b.is_act = 1; b.addr = 8'(i); mq.push_back(b); end
                e_rdy = 0; e_bsy = 1; m_mode = 1;
                model_issue(st);
            end
            1: model_issue(st);
            2: begin e_cs = 1; e_aa = 0; m_mode = 3; end
            3: if (cd) begin e_dn = 1; m_mode = 4; end
            default: begin e_rdy = 1; e_bsy = 0; m_mode = 0; end
        endcase
    endfunction

    function automatic void check_trace(string nm);
        chk(nm, 32'(dut_vec()), 32'(pack(e_rdy, e_wl, e_wa, e_av, e_aa, e_cs, e_bsy, e_dn)));
    endfunction

    function automatic void chk_seq(string nm, bit is_act, int n);
        int got[$];
        bit ok;
        if (is_act) got = aq; else got = wq;
        ok = (got.size() == n);
        foreach (got[i]) if (got[i] != i) ok = 0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got addresses %p required 0..%0d", nm, got, n - 1);
        end
    endfunction

    // One clock: drive inputs, step model at the edge, compare at the negedge.
    // With emu_on the bench plays the drain Counter: cnt_done_i CNT_D cycles after cnt_start_o.
    task automatic cycle(input bit s, input bit st, input bit cdx, input string nm);
        bit cd;
        cd = cdx | (emu_on && emu_timer == 0);
        if (emu_timer >= 0) emu_timer--;
        start_i = s; stall_i = st; cnt_done_i = cd;
        @(posedge clk);
        model_step(s, st, cd);
        @(negedge clk);
        check_trace(nm);
        if (w_load_o)    wq.push_back(int'(w_addr_o));
        if (act_valid_o) aq.push_back(int'(act_addr_o));
        if (emu_on && cnt_start_o) emu_timer = CNT_D;
    endtask

    task automatic run_tile(input bit use_stall, output int lat, output bit ok);
        int stall_left;
        bit st;
        stall_left = 0; ok = 0; lat = 0;
        wq.delete(); aq.delete();
        emu_on = 1; emu_timer = -1;
        for (int k = 0; k < 200 && !ok; k++) begin
            st = (stall_left > 0);
            if (st) stall_left--;
            cycle(k == 0, st, 1'b0, "tile");
            lat++;
            if (done_o) ok = 1;
            if (use_stall && w_load_o && w_addr_o == 2) stall_left = 3;
            if (use_stall && act_valid_o && act_addr_o == 4) stall_left = 2;
        end
        emu_on = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit ok;
        bit found;

        tv[0]  = mk(1,0,0, 0,1,0, 0,0, 0,1,0);
        tv[1]  = mk(0,0,0, 0,1,1, 0,0, 0,1,0);
        tv[2]  = mk(1,0,0, 0,1,2, 0,0, 0,1,0);
        tv[3]  = mk(1,0,0, 0,1,3, 0,0, 0,1,0);
        tv[4]  = mk(0,0,0, 0,0,0, 1,0, 0,1,0);
        tv[5]  = mk(0,0,1, 0,0,0, 1,1, 0,1,0);
        tv[6]  = mk(0,0,0, 0,0,0, 1,2, 0,1,0);
        tv[7]  = mk(0,0,0, 0,0,0, 1,3, 0,1,0);
        tv[8]  = mk(0,0,0, 0,0,0, 1,4, 0,1,0);
        tv[9]  = mk(0,0,0, 0,0,0, 1,5, 0,1,0);
        tv[10] = mk(0,0,1, 0,0,0, 0,0, 1,1,0);
        tv[11] = mk(0,0,1, 0,0,0, 0,0, 0,1,1);
        tv[12] = mk(0,0,0, 1,0,0, 0,0, 0,0,0);
        tv[13] = mk(0,0,0, 1,0,0, 0,0, 0,0,0);

        rst_n = 0; start_i = 0; stall_i = 0; cnt_done_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_trace("reset_hold");
        rst_n = 1;
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, "idle_after_reset");

        for (int i = 0; i < NV; i++) begin
            start_i = tv[i].s; stall_i = tv[i].st; cnt_done_i = tv[i].cd;
            @(posedge clk);
            model_step(tv[i].s, tv[i].st, tv[i].cd);
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(dut_vec()),
                32'(pack(tv[i].rdy, tv[i].wl, tv[i].wa, tv[i].av, tv[i].aa,
                         tv[i].cs, tv[i].bsy, tv[i].dn)));
        end

        run_tile(0, lat, ok);
        chk("nominal_done_seen", 32'(ok), 1);
        chk("nominal_latency", lat, AS + AL + CNT_D + 2);
        chk_seq("nominal_w_seq", 0, AS);
        chk_seq("nominal_a_seq", 1, AL);
        cycle(0, 0, 0, "spacer");
        chk("ready_after_done", 32'(ready_o), 1);

        run_tile(0, lat, ok);
        chk("b2b_done_seen", 32'(ok), 1);
        chk("b2b_latency", lat, AS + AL + CNT_D + 2);
        chk_seq("b2b_w_seq", 0, AS);
        chk_seq("b2b_a_seq", 1, AL);
        cycle(0, 0, 0, "spacer");

        run_tile(1, lat, ok);
        chk("stall_done_seen", 32'(ok), 1);
        chk("stall_latency", lat, AS + AL + CNT_D + 2 + 5);
        chk_seq("stall_w_seq", 0, AS);
        chk_seq("stall_a_seq", 1, AL);
        cycle(0, 0, 0, "spacer");

        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            cycle(k == 0, 0, 0, "pre_reset");
            if (act_valid_o && act_addr_o == 3) found = 1;
        end
        chk("reached_act3", 32'(found), 1);
        start_i = 0; stall_i = 0; cnt_done_i = 0;
        rst_n = 0;
        #1;
        model_reset();
        emu_timer = -1;
        check_trace("reset_async");
        @(negedge clk);
        check_trace("reset_held");
        rst_n = 1;
        run_tile(0, lat, ok);
        chk("post_reset_done_seen", 32'(ok), 1);
        chk("post_reset_latency", lat, AS + AL + CNT_D + 2);
        chk_seq("post_reset_w_seq", 0, AS);
        chk_seq("post_reset_a_seq", 1, AL);
        cycle(0, 0, 0, "spacer");

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
